// File: rtl/mac_pkg.sv
// Shared types and helpers for the multiply-accumulate block.
// Build option MAC_ACCUM_SAT_EN selects saturating instead of wrapping adds.
package mac_pkg;

   localparam int PROD_W = 16;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACC,
      S_DONE
   } state_t;

   function automatic logic [31:0] smax(input int w);
      logic [31:0] v;
      v = 32'h1 << (w - 1);
      return v - 32'h1;
   endfunction

   function automatic logic [31:0] smin(input int w);
      return ~smax(w);
   endfunction

endpackage

// File: rtl/sat_add.sv
// Signed W-bit adder with overflow flag; clamps on overflow when
// MAC_ACCUM_SAT_EN is defined, otherwise wraps modulo 2^W.
module sat_add
   import mac_pkg::*;
#(
   parameter int W = 24
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         ovf
);

   logic [W:0] w_sum;

   assign w_sum = {a[W-1], a} + {b[W-1], b};
   // True sum fits only if the two top bits of the widened result agree
   assign ovf   = w_sum[W] ^ w_sum[W-1];

`ifdef MAC_ACCUM_SAT_EN
   logic [W-1:0] w_max;
   logic [W-1:0] w_min;

   assign w_max = W'(smax(W));
   assign w_min = W'(smin(W));
   assign sum   = ovf ? (w_sum[W] ? w_min : w_max) : w_sum[W-1:0];
`else
   assign sum   = w_sum[W-1:0];
`endif

endmodule

// File: rtl/mac_accum.sv
// Counted multiply-accumulate with valid/ready in and out.
// Define MAC_ACCUM_SAT_EN for a saturating accumulator.
module mac_accum
   import mac_pkg::*;
#(
   parameter int ACC_W = 24,
   parameter int LEN_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              ovf,
   output logic              busy
);

   localparam int CNT_W = LEN_W + 1;

   state_t             r_state;
   state_t             w_next;
   logic [ACC_W-1:0]   r_acc;
   logic               r_ovf;
   logic [CNT_W-1:0]   r_cnt;
   logic [ACC_W-1:0]   w_prod;
   logic [ACC_W-1:0]   w_sum;
   logic               w_add_ovf;
   logic               w_fire;
   logic               w_load;

   assign w_prod = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
   assign w_fire = (r_state == S_ACC) && in_valid;
   assign w_load = (r_state == S_IDLE) && start;

   sat_add #(
      .W (ACC_W)
   ) u_add (
      .a   (r_acc),
      .b   (w_prod),
      .sum (w_sum),
      .ovf (w_add_ovf)
   );

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (start) w_next = S_ACC;
         S_ACC:   if (in_valid && r_cnt == CNT_W'(1)) w_next = S_DONE;
         S_DONE:  if (out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_acc   <= '0;
         r_ovf   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_load) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            // len of zero encodes the full 2^LEN_W term count
            r_cnt <= {(len == '0), len};
         end else if (w_fire) begin
            r_acc <= w_sum;
            r_ovf <= r_ovf | w_add_ovf;
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end
   end

   assign in_ready  = (r_state == S_ACC);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
   assign acc_out   = r_acc;
   assign ovf       = r_ovf;

endmodule

// File: doc/mac_accum.md
MAC_ACCUM -- requirements
Module: mac_accum

Interface
REQ-001 The block SHALL have parameter ACC_W, default 24, accumulator width in bits, legal range 17..32.
REQ-002 The block SHALL have parameter LEN_W, default 4, width of the term-count field.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port start, input, 1 bit: begins a new accumulation; accepted only in IDLE.
REQ-006 Port len, input, LEN_W bits: number of terms; value 0 SHALL mean 2^LEN_W terms; sampled with start.
REQ-007 Port in_valid, input, 1 bit: prod is valid.
REQ-008 Port in_ready, output, 1 bit: block accepts prod.
REQ-009 Port prod, input, 16 bits: signed two's-complement product from the upstream multiplier.
REQ-010 Port out_valid, output, 1 bit: acc_out holds the final result.
REQ-011 Port out_ready, input, 1 bit: downstream consumes the result.
REQ-012 Port acc_out, output, ACC_W bits: signed accumulated sum.
REQ-013 Port ovf, output, 1 bit: sticky signed-overflow flag for the current accumulation.
REQ-014 Port busy, output, 1 bit: high in every state other than IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACC and DONE.
REQ-016 IDLE: start=1 SHALL clear the accumulator and ovf, load the term counter from len, and move to ACC on the next edge.
REQ-017 ACC: in_ready SHALL be 1; each cycle with in_valid & in_ready SHALL add sign-extended prod to the accumulator and decrement the counter.
REQ-018 Cycles in ACC with in_valid=0 SHALL leave the accumulator and counter unchanged.
REQ-019 Accepting the last term SHALL move the FSM to DONE, so out_valid rises on the cycle after the final handshake.
REQ-020 DONE: out_valid=1, in_ready=0, and acc_out and ovf SHALL be held stable until out_valid & out_ready, after which the FSM returns to IDLE.
REQ-021 in_ready SHALL be 0 in IDLE and DONE.
REQ-022 start SHALL be ignored in ACC and DONE.
REQ-023 A start in the same cycle as the DONE->IDLE handshake SHALL be ignored; start is honoured from IDLE only.
REQ-024 ovf SHALL set when any single addition produces a true sum outside the ACC_W signed range, and SHALL remain set until the next accepted start or reset.
REQ-025 acc_out SHALL present the live accumulator in ACC and the final value in DONE.

Reset
REQ-026 With rst_n=0 at a clock edge, the block SHALL enter IDLE with the accumulator and counter at 0, and the outputs in_ready=0, out_valid=0, acc_out=0, ovf=0 and busy=0.
REQ-027 Reset SHALL override every other input, including mid-ACC and mid-DONE; no partial result SHALL survive it.

Configuration
REQ-028 With macro MAC_ACCUM_SAT_EN defined, an overflowing addition SHALL clamp the accumulator to the signed maximum (positive overflow) or minimum (negative overflow), and later terms SHALL add to the clamped value.
REQ-029 Without MAC_ACCUM_SAT_EN, additions SHALL wrap modulo 2^ACC_W.
REQ-030 ovf behaviour SHALL be identical in both builds.

Structure
REQ-031 Package mac_pkg SHALL hold the FSM state typedef, the PROD_W=16 constant, and functions returning the signed max/min for a given width.
REQ-032 Saturating/wrapping addition SHALL live in one sub-module, sat_add (inputs a, b, outputs sum, ovf), selected by MAC_ACCUM_SAT_EN.
REQ-033 The FSM, counter and handshake logic SHALL live in mac_accum itself.

Verification
REQ-034 len=3, prods 5, -2, 100 with no bubbles -> out_valid=1 one cycle after the third handshake, acc_out=103, ovf=0.
REQ-035 len=0, sixteen prods of 0x8000 (-32768) -> acc_out=0xF80000 (-524288), ovf=0.
REQ-036 ACC_W=17, len=3, three prods of 0x7FFF: with MAC_ACCUM_SAT_EN -> acc_out=0x0FFFF and ovf=1; without -> acc_out=0x17FFD and ovf=1.
REQ-037 After the result is reached, hold out_ready=0 for 5 cycles and pulse start -> out_valid stays 1, acc_out is stable, in_ready=0, start is ignored; out_ready=1 -> IDLE on the next cycle.
REQ-038 len=4 with in_valid deasserted for 3 cycles between terms -> only handshakes count, and acc_out equals the sum of the 4 terms.
REQ-039 rst_n=0 for one cycle after 2 of 4 terms -> next cycle IDLE, acc_out=0, out_valid=0, busy=0; a fresh start then accumulates from 0.
